rr_output_arbiter: RTL and testbench

//  Round-robin arbiter for one router output port. One instance per direction sits between
//  the input FIFOs and that port's tx serializer. Picks one requesting FIFO, pops its head flit,
//  and hands it to tx over the ena/busy handshake. Holds the grant until tx finishes the flit.

---
 rtl/rr_output_arbiter_pkg.sv | 19 +
 rtl/rr_output_arbiter_pick.sv | 31 +++
 rtl/rr_output_arbiter.sv | 124 ++++++++++++
 tb/tb_rr_output_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_output_arbiter_pkg.sv
// rtl/rr_output_arbiter_pkg.sv - router-wide defines and arbiter state encoding
package rr_output_arbiter_pkg;

  localparam int DIRECTIONS   = 5;
  localparam int NORTH        = 0;
  localparam int EAST         = 1;
  localparam int SOUTH        = 2;
  localparam int WEST         = 3;
  localparam int LOCAL        = 4;
  localparam int PAYLOAD_SIZE = 8;
  localparam int ADDR_SZ      = 4;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_WAIT = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_output_arbiter_pick.sv
// rtl/rr_output_arbiter_pick.sv - combinational round-robin priority rotator (rr_pick)
// Scans ptr+1, ptr+2, ... mod N and returns the first requester one-hot.
module rr_pick #(
  parameter int N  = 5,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic          any
);

  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    onehot = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 1; k <= N; k++) begin
      idx = PW'((int'(ptr) + k) % N);
      if (!found && req[idx]) begin
        onehot[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/rr_output_arbiter.sv
// rtl/rr_output_arbiter.sv - round-robin output port arbiter with ena/busy tx handshake
// Optional ARB_STALL_CNT_EN adds a saturating stall_cnt output.
module rr_output_arbiter
  import rr_output_arbiter_pkg::*;
#(
  parameter int PORTID      = NORTH,
  parameter int N           = DIRECTIONS,
  parameter int W           = PAYLOAD_SIZE + ADDR_SZ,
  parameter int ALLOW_UTURN = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] item_in,
  output logic [N-1:0]   pop,
  output logic [W-1:0]   item_out,
  output logic           ena,
  input  logic           busy,
  output logic [N-1:0]   grant
`ifdef ARB_STALL_CNT_EN
  ,
  output logic [15:0]    stall_cnt
`endif
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  arb_state_e    state_q;
  logic [PW-1:0] ptr_q;
  logic [N-1:0]  grant_q;
  logic [W-1:0]  item_q;
  logic          ena_q;

  logic [N-1:0]  uturn_mask;
  logic [N-1:0]  eff_req;
  logic [N-1:0]  pick_oh;
  logic          pick_any;
  logic          start;
  logic [W-1:0]  item_sel;
  logic [PW-1:0] owner_idx;

  assign uturn_mask = (ALLOW_UTURN != 0) ? '0 : (N'(1) << PORTID);
  assign eff_req    = req & ~uturn_mask;

  rr_pick #(.N(N), .PW(PW)) u_pick (
    .req    (eff_req),
    .ptr    (ptr_q),
    .onehot (pick_oh),
    .any    (pick_any)
  );

  // Pop is combinational so the FIFO advances on the same edge the flit is captured.
  assign start = (state_q == ARB_IDLE) && pick_any && !busy && !reset;
  assign pop   = start ? pick_oh : '0;

  always_comb begin
    item_sel = '0;
    for (int i = 0; i < N; i++) begin
      if (pick_oh[i]) item_sel = item_sel | item_in[i*W +: W];
    end
  end

  always_comb begin
    owner_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_q[i]) owner_idx = PW'(i);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ARB_IDLE;
      ptr_q   <= PW'(N - 1);
      grant_q <= '0;
      item_q  <= '0;
      ena_q   <= 1'b0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (start) begin
            grant_q <= pick_oh;
            item_q  <= item_sel;
            ena_q   <= 1'b1;
            state_q <= ARB_REQ;
          end
        end
        ARB_REQ: begin
          if (busy) begin
            ena_q   <= 1'b0;
            state_q <= ARB_WAIT;
          end
        end
        ARB_WAIT: begin
          // Last winner becomes lowest priority for the next scan.
          if (!busy) begin
            ptr_q   <= owner_idx;
            grant_q <= '0;
            state_q <= ARB_IDLE;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign grant    = grant_q;
  assign item_out = item_q;
  assign ena      = ena_q;

`ifdef ARB_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
    end else if ((|req) && busy && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_rr_output_arbiter.sv
// tb/tb_rr_output_arbiter.sv - randomized and directed bench with behavioural model for rr_output_arbiter
module tb_rr_output_arbiter;
  import rr_output_arbiter_pkg::*;

  localparam int N = 5;
  localparam int W = 12;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic [N*W-1:0] item_in;
  logic           busy;
  logic [N-1:0]   pop_a, grant_a, pop_b, grant_b;
  logic [W-1:0]   item_a, item_b;
  logic           ena_a, ena_b;
`ifdef ARB_STALL_CNT_EN
  logic [15:0]    stall_a, stall_b;
`endif

  always #5 clk = ~clk;

  rr_output_arbiter #(.PORTID(0), .N(N), .W(W), .ALLOW_UTURN(1)) u_dut_a (
    .clk(clk), .reset(reset), .req(req), .item_in(item_in), .pop(pop_a),
    .item_out(item_a), .ena(ena_a), .busy(busy), .grant(grant_a)
`ifdef ARB_STALL_CNT_EN
    , .stall_cnt(stall_a)
`endif
  );

  rr_output_arbiter #(.PORTID(1), .N(N), .W(W), .ALLOW_UTURN(0)) u_dut_b (
    .clk(clk), .reset(reset), .req(req), .item_in(item_in), .pop(pop_b),
    .item_out(item_b), .ena(ena_b), .busy(busy), .grant(grant_b)
`ifdef ARB_STALL_CNT_EN
    , .stall_cnt(stall_b)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: owner = input holding the port (-1 when free), acked = tx has taken the flit.
  int           owner[2];
  int           last[2];
  bit           acked[2];
  logic [W-1:0] mitem[2];
  int           stall_m;

  logic [N-1:0] s_pop[2];
  logic [N-1:0] s_grant[2];
  logic         s_ena[2];
  logic [W-1:0] s_item[2];
  int           pops_a;
  int           glog[$];
  int           bcnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] eff_of(input int c);
    logic [N-1:0] e;
    e = req;
    if (c == 1) e[1] = 1'b0;
    return e;
  endfunction

  function automatic int pick(input int c);
    logic [N-1:0] e;
    int p;
    e = eff_of(c);
    p = -1;
    for (int k = 1; k <= N; k++) begin
      if (p < 0 && e[(last[c] + k) % N]) p = (last[c] + k) % N;
    end
    return p;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      owner[c] = -1;
      last[c]  = N - 1;
      acked[c] = 1'b0;
      mitem[c] = '0;
    end
    stall_m = 0;
  endtask

  task automatic tick();
    int w;
    logic [N-1:0] ep, eg;
    @(negedge clk);
    s_pop[0] = pop_a;   s_pop[1] = pop_b;
    s_grant[0] = grant_a; s_grant[1] = grant_b;
    s_ena[0] = ena_a;   s_ena[1] = ena_b;
    s_item[0] = item_a; s_item[1] = item_b;
    if (reset) model_reset();
    for (int c = 0; c < 2; c++) begin
      w  = (!reset && owner[c] < 0 && !busy) ? pick(c) : -1;
      ep = (w >= 0) ? (N'(1) << w) : '0;
      eg = (owner[c] >= 0) ? (N'(1) << owner[c]) : '0;
      check($sformatf("pop[%0d]", c), 32'(s_pop[c]), 32'(ep));
      check($sformatf("grant[%0d]", c), 32'(s_grant[c]), 32'(eg));
      check($sformatf("ena[%0d]", c), 32'(s_ena[c]), 32'(owner[c] >= 0 && !acked[c]));
      check($sformatf("item_out[%0d]", c), 32'(s_item[c]), 32'(mitem[c]));
      if (!reset) begin
        if (owner[c] < 0) begin
          if (w >= 0) begin
            owner[c] = w;
            acked[c] = 1'b0;
            mitem[c] = item_in[w*W +: W];
          end
        end else if (!acked[c]) begin
          if (busy) acked[c] = 1'b1;
        end else if (!busy) begin
          last[c]  = owner[c];
          owner[c] = -1;
        end
      end
    end
`ifdef ARB_STALL_CNT_EN
    check("stall_cnt[0]", 32'(stall_a), 32'(stall_m));
    check("stall_cnt[1]", 32'(stall_b), 32'(stall_m));
`endif
    if (!reset && (|req) && busy && stall_m < 65535) stall_m++;
    if (s_pop[0] != '0) begin
      pops_a++;
      for (int i = 0; i < N; i++) if (s_pop[0][i]) glog.push_back(i);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; req = '0; busy = 1'b0; item_in = '0; bcnt = 0;
    tick(); tick();
    reset = 1'b0;
  endtask

  // Emulated tx: takes a flit when ena is seen and stays busy for 4 cycles.
  task automatic tx_step();
    if (s_ena[0] && !busy && bcnt == 0) bcnt = 4;
    busy = (bcnt > 0);
    if (bcnt > 0) bcnt--;
  endtask

  task automatic finish_flit();
    req = '0; busy = 1'b1;
    tick();
    busy = 1'b0;
    tick();
  endtask

  initial begin
    int exp_order[6];
    exp_order = '{0, 1, 2, 3, 4, 0};
    reset = 1'b1; req = '0; busy = 1'b0; item_in = '0; bcnt = 0; pops_a = 0;
    model_reset();
    tick();
    check("reset_grant", 32'(grant_a), 32'h0);
    check("reset_item", 32'(item_a), 32'h0);
    check("reset_ena", 32'(ena_a), 32'h0);
    do_reset();

    // Single request.
    req = 5'b00100; item_in[2*W +: W] = 12'h0A5;
    tick();
    check("t1_pop", 32'(s_pop[0]), 32'h04);
    req = '0;
    tick();
    check("t1_ena", 32'(s_ena[0]), 32'h1);
    check("t1_item", 32'(s_item[0]), 32'h0A5);
    busy = 1'b1;
    tick(); tick();
    check("t1_ena_drop", 32'(s_ena[0]), 32'h0);
    busy = 1'b0;
    tick(); tick();
    check("t1_grant_clear", 32'(s_grant[0]), 32'h0);

    // All request, busy pulsed 4 cycles per flit.
    do_reset();
    pops_a = 0; glog.delete();
    for (int i = 0; i < N; i++) item_in[i*W +: W] = W'(12'h100 + i);
    req = '1;
    for (int cyc = 0; cyc < 200 && pops_a < 6; cyc++) begin
      tick();
      if (pops_a >= 6) req = '0;
      tx_step();
    end
    for (int cyc = 0; cyc < 12; cyc++) begin
      tick();
      tx_step();
    end
    check("t2_pop_count", 32'(pops_a), 32'd6);
    for (int i = 0; i < 6; i++)
      check($sformatf("t2_order%0d", i), (i < glog.size()) ? 32'(glog[i]) : 32'hFFFFFFFF,
            32'(exp_order[i]));

    // busy held in IDLE.
    do_reset();
    pops_a = 0;
    req = '1; busy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t3_ena", 32'(s_ena[0]), 32'h0);
    end
    check("t3_pops", 32'(pops_a), 32'd0);
`ifdef ARB_STALL_CNT_EN
    check("t3_stall", 32'(stall_a), 32'd10);
`endif

    // No u-turn on instance b.
    do_reset();
    req = 5'b00010;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("t4_no_grant", 32'(s_grant[1]), 32'h0);
    end
    req = 5'b00011;
    tick();
    check("t4_pop0", 32'(s_pop[1]), 32'h01);

    // Reset mid-flit.
    do_reset();
    req = 5'b00001; item_in[0 +: W] = 12'h03C;
    tick();
    req = '0;
    tick();
    check("t5_item", 32'(s_item[0]), 32'h03C);
    reset = 1'b1;
    tick();
    check("t5_rst_ena", 32'(s_ena[0]), 32'h0);
    check("t5_rst_item", 32'(s_item[0]), 32'h0);
    check("t5_rst_grant", 32'(s_grant[0]), 32'h0);
    reset = 1'b0; req = 5'b00001;
    tick();
    check("t5_regrant", 32'(s_pop[0]), 32'h01);

    // Fairness after input 4 wins.
    do_reset();
    req = 5'b10000;
    tick();
    check("t6_first", 32'(s_pop[0]), 32'h10);
    finish_flit();
    req = 5'b10001;
    tick();
    check("t6_second", 32'(s_pop[0]), 32'h01);
    finish_flit();
    req = 5'b10001;
    tick();
    check("t6_third", 32'(s_pop[0]), 32'h10);
    finish_flit();

    // Randomized traffic.
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      req  = N'($urandom);
      busy = ($urandom_range(0, 2) == 0);
      for (int i = 0; i < N; i++) item_in[i*W +: W] = W'($urandom);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
